// File: rtl/gain_arbiter.sv
// rtl/gain_arbiter.sv - round-robin, credit-based scheduler sharing one gain pipeline between L/R channels
// Optional GAIN_ARB_MUTE_EN adds a mute input that zeroes the written result of samples granted while muted.
module gain_arbiter #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    GAIN_WIDTH   = 32,
    parameter int                    GAIN_LATENCY = 3,
    parameter int                    OUT_DEPTH    = 8,
    parameter logic [GAIN_WIDTH-1:0] GAIN_DEFAULT = 32'h00000400
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  l_in_empty,
    output logic                  l_in_rd_en,
    input  logic [DATA_WIDTH-1:0] l_in_dout,
    input  logic                  r_in_empty,
    output logic                  r_in_rd_en,
    input  logic [DATA_WIDTH-1:0] r_in_dout,
    output logic                  g_valid,
    output logic [DATA_WIDTH-1:0] g_din,
    output logic [GAIN_WIDTH-1:0] g_gain,
    input  logic [DATA_WIDTH-1:0] g_dout,
    output logic                  l_out_wr_en,
    output logic [DATA_WIDTH-1:0] l_out_din,
    input  logic                  l_out_pop,
    output logic                  r_out_wr_en,
    output logic [DATA_WIDTH-1:0] r_out_din,
    input  logic                  r_out_pop,
    input  logic                  cfg_wr,
    input  logic                  cfg_sel,
    input  logic [GAIN_WIDTH-1:0] cfg_gain,
`ifdef GAIN_ARB_MUTE_EN
    input  logic                  mute,
`endif
    output logic                  busy
);

    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(OUT_DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);
    localparam int LAST = GAIN_LATENCY - 1;

    logic [CW-1:0]           l_credit, r_credit;
    logic [GAIN_WIDTH-1:0]   l_gain, r_gain;
    logic                    last_r;
    logic                    l_elig, r_elig, grant_l, grant_r;

    logic                    iss_valid, iss_tag;
    logic [DATA_WIDTH-1:0]   iss_data;
    logic [GAIN_WIDTH-1:0]   iss_gain;
    logic [GAIN_LATENCY-1:0] tag_v, tag_r;
    logic [DATA_WIDTH-1:0]   wb_data;

    // Credit update: a grant and a pop together cancel; pops at full credit are dropped.
    function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] c, input logic g, input logic p);
        logic up;
        up = p && (c != CREDIT_FULL);
        if (g && !p)
            return c - CREDIT_ONE;
        else if (up && !g)
            return c + CREDIT_ONE;
        else
            return c;
    endfunction

    assign l_elig = !l_in_empty && (l_credit != '0);
    assign r_elig = !r_in_empty && (r_credit != '0);

    // No pops during reset, otherwise the popped sample would be lost.
    always_comb begin
        grant_l = 1'b0;
        grant_r = 1'b0;
        if (reset) begin
            if (l_elig && (!r_elig || last_r))
                grant_l = 1'b1;
            else if (r_elig)
                grant_r = 1'b1;
        end
    end

    assign l_in_rd_en = grant_l;
    assign r_in_rd_en = grant_r;
    assign g_valid    = iss_valid;
    assign g_din      = iss_data;
    assign g_gain     = iss_gain;
    assign busy       = iss_valid | (|tag_v);

`ifdef GAIN_ARB_MUTE_EN
    logic                    iss_mute;
    logic [GAIN_LATENCY-1:0] tag_m;

    assign wb_data = tag_m[LAST] ? '0 : g_dout;

    always_ff @(posedge clock) begin
        if (!reset) begin
            iss_mute <= 1'b0;
            tag_m    <= '0;
        end else begin
            if (grant_l || grant_r)
                iss_mute <= mute;
            tag_m[0] <= iss_mute;
            for (int i = 1; i < GAIN_LATENCY; i++)
                tag_m[i] <= tag_m[i-1];
        end
    end
`else
    assign wb_data = g_dout;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            l_credit    <= CREDIT_FULL;
            r_credit    <= CREDIT_FULL;
            l_gain      <= GAIN_DEFAULT;
            r_gain      <= GAIN_DEFAULT;
            last_r      <= 1'b1;
            iss_valid   <= 1'b0;
            iss_tag     <= 1'b0;
            iss_data    <= '0;
            iss_gain    <= GAIN_DEFAULT;
            tag_v       <= '0;
            tag_r       <= '0;
            l_out_wr_en <= 1'b0;
            r_out_wr_en <= 1'b0;
            l_out_din   <= '0;
            r_out_din   <= '0;
        end else begin
            if (cfg_wr) begin
                if (cfg_sel)
                    r_gain <= cfg_gain;
                else
                    l_gain <= cfg_gain;
            end

            l_credit <= credit_next(l_credit, grant_l, l_out_pop);
            r_credit <= credit_next(r_credit, grant_r, r_out_pop);

            if (grant_l || grant_r)
                last_r <= grant_r;

            // Gain register is sampled here, so a same-edge cfg write only affects later grants.
            iss_valid <= grant_l | grant_r;
            iss_tag   <= grant_r;
            if (grant_l || grant_r) begin
                iss_data <= grant_r ? r_in_dout : l_in_dout;
                iss_gain <= grant_r ? r_gain : l_gain;
            end

            tag_v[0] <= iss_valid;
            tag_r[0] <= iss_tag;
            for (int i = 1; i < GAIN_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_r[i] <= tag_r[i-1];
            end

            l_out_wr_en <= tag_v[LAST] && !tag_r[LAST];
            r_out_wr_en <= tag_v[LAST] && tag_r[LAST];
            if (tag_v[LAST] && !tag_r[LAST])
                l_out_din <= wb_data;
            if (tag_v[LAST] && tag_r[LAST])
                r_out_din <= wb_data;
        end
    end

endmodule

// File: tb/tb_gain_arbiter.sv
// tb/tb_gain_arbiter.sv - directed bench for gain_arbiter with FWFT input FIFO and identity gain-unit models
module tb_gain_arbiter;

    localparam int GL = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        l_in_empty = 1'b1, r_in_empty = 1'b1;
    logic        l_in_rd_en, r_in_rd_en;
    logic [31:0] l_in_dout = '0, r_in_dout = '0;
    logic        g_valid;
    logic [31:0] g_din, g_gain;
    logic [31:0] g_dout = '0;
    logic        l_out_wr_en, r_out_wr_en;
    logic [31:0] l_out_din, r_out_din;
    logic        l_out_pop = 1'b0, r_out_pop = 1'b0;
    logic        cfg_wr = 1'b0, cfg_sel = 1'b0;
    logic [31:0] cfg_gain = '0;
    logic        busy;
`ifdef GAIN_ARB_MUTE_EN
    logic        mute = 1'b0;
`endif

    gain_arbiter #(
        .DATA_WIDTH(32), .GAIN_WIDTH(32), .GAIN_LATENCY(GL), .OUT_DEPTH(8), .GAIN_DEFAULT(32'h400)
    ) dut (
        .clock(clock), .reset(reset),
        .l_in_empty(l_in_empty), .l_in_rd_en(l_in_rd_en), .l_in_dout(l_in_dout),
        .r_in_empty(r_in_empty), .r_in_rd_en(r_in_rd_en), .r_in_dout(r_in_dout),
        .g_valid(g_valid), .g_din(g_din), .g_gain(g_gain), .g_dout(g_dout),
        .l_out_wr_en(l_out_wr_en), .l_out_din(l_out_din), .l_out_pop(l_out_pop),
        .r_out_wr_en(r_out_wr_en), .r_out_din(r_out_din), .r_out_pop(r_out_pop),
        .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_gain(cfg_gain),
`ifdef GAIN_ARB_MUTE_EN
        .mute(mute),
`endif
        .busy(busy)
    );

    always #5 clock = ~clock;

    int          tests = 0, fails = 0;
    int          cyc = 0;
    logic [31:0] lq[$], rq[$];
    int          lg_cyc[$], rg_cyc[$], lw_cyc[$];
    logic [31:0] lw[$], rw[$], gains[$];
    int          gv_n = 0, overlap = 0;
    logic        l_auto = 1'b0, r_auto = 1'b0;
    logic [31:0] gd[GL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_inputs();
        l_in_empty = (lq.size() == 0);
        l_in_dout  = l_in_empty ? 32'h0 : lq[0];
        r_in_empty = (rq.size() == 0);
        r_in_dout  = r_in_empty ? 32'h0 : rq[0];
    endtask

    task automatic clear_log();
        lg_cyc.delete(); rg_cyc.delete(); lw_cyc.delete();
        lw.delete(); rw.delete(); gains.delete();
        gv_n = 0; overlap = 0;
    endtask

    // One clock: observe at the falling edge, then model FIFO pops / gain unit / consumer after the rising edge.
    task automatic cycle();
        logic lrd, rrd, lwr, rwr;
        @(negedge clock);
        lrd = l_in_rd_en; rrd = r_in_rd_en; lwr = l_out_wr_en; rwr = r_out_wr_en;
        if (lrd) lg_cyc.push_back(cyc);
        if (rrd) rg_cyc.push_back(cyc);
        if (lrd && rrd) overlap++;
        if (g_valid) begin gv_n++; gains.push_back(g_gain); end
        if (lwr) begin lw.push_back(l_out_din); lw_cyc.push_back(cyc); end
        if (rwr) rw.push_back(r_out_din);
        for (int i = GL - 1; i > 0; i--) gd[i] = gd[i-1];
        gd[0] = g_din;
        @(posedge clock);
        #1;
        cyc++;
        if (lrd) void'(lq.pop_front());
        if (rrd) void'(rq.pop_front());
        update_inputs();
        g_dout    = gd[GL-1];
        l_out_pop = l_auto && lwr;
        r_out_pop = r_auto && rwr;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        l_auto = 1'b0; r_auto = 1'b0;
        lq.delete(); rq.delete();
        update_inputs();
        cfg_wr = 1'b0;
        cycle();
        l_out_pop = 1'b0; r_out_pop = 1'b0;
        reset = 1'b1;
        clear_log();
    endtask

    initial begin
        int bad;
        for (int i = 0; i < GL; i++) gd[i] = '0;

        // Reset state
        reset = 1'b0;
        cycle();
        chk("rst_l_rd_en", {31'd0, l_in_rd_en}, 32'd0);
        chk("rst_r_rd_en", {31'd0, r_in_rd_en}, 32'd0);
        chk("rst_g_valid", {31'd0, g_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_l_wr_en", {31'd0, l_out_wr_en}, 32'd0);
        chk("rst_r_wr_en", {31'd0, r_out_wr_en}, 32'd0);
        chk("rst_g_din", g_din, 32'd0);
        chk("rst_l_out_din", l_out_din, 32'd0);
        chk("rst_r_out_din", r_out_din, 32'd0);
        do_reset();

        // Left-only burst 5,6,7
        lq.push_back(32'd5); lq.push_back(32'd6); lq.push_back(32'd7);
        update_inputs();
        run(12);
        chk("t1_l_grants", lg_cyc.size(), 3);
        chk("t1_l_consecutive", lg_cyc[2] - lg_cyc[0], 2);
        chk("t1_latency", lw_cyc[0] - lg_cyc[0], 5);
        chk("t1_lw0", lw[0], 32'd5);
        chk("t1_lw1", lw[1], 32'd6);
        chk("t1_lw2", lw[2], 32'd7);
        chk("t1_r_writes", rw.size(), 0);
        chk("t1_gain", gains[0], 32'h400);

        // Both channels busy, outputs drained: strict alternation starting with L
        do_reset();
        for (int i = 0; i < 8; i++) begin
            lq.push_back(32'd100 + i);
            rq.push_back(32'd200 + i);
        end
        update_inputs();
        l_auto = 1'b1; r_auto = 1'b1;
        run(30);
        chk("t2_l_grants", lg_cyc.size(), 8);
        chk("t2_r_grants", rg_cyc.size(), 8);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (rg_cyc[i] != lg_cyc[i] + 1) bad++;
            if (i < 7 && lg_cyc[i+1] != rg_cyc[i] + 1) bad++;
            if (lw[i] !== 32'd100 + i) bad++;
            if (rw[i] !== 32'd200 + i) bad++;
        end
        chk("t2_alternate_and_route", bad, 0);
        chk("t2_g_valid_count", gv_n, 16);
        chk("t2_overlap", overlap, 0);

        // Right output never drained: right stalls at 8 credits, left keeps full rate
        do_reset();
        for (int i = 0; i < 12; i++) begin
            lq.push_back(32'd300 + i);
            rq.push_back(32'd400 + i);
        end
        update_inputs();
        l_auto = 1'b1;
        run(30);
        chk("t3_r_grants_capped", rg_cyc.size(), 8);
        chk("t3_l_grants", lg_cyc.size(), 12);
        chk("t3_l_full_rate", lg_cyc[11] - lg_cyc[0], 19);
        r_out_pop = 1'b1;
        cycle();
        run(20);
        chk("t3_one_more_r_grant", rg_cyc.size(), 9);
        chk("t3_r_writes", rw.size(), 9);
        chk("t3_rw8", rw[8], 32'd408);

        // Gain write coinciding with a right grant
        do_reset();
        rq.push_back(32'h51); rq.push_back(32'h52);
        update_inputs();
        cfg_wr = 1'b1; cfg_sel = 1'b1; cfg_gain = 32'h800;
        cycle();
        cfg_wr = 1'b0;
        run(8);
        lq.push_back(32'h61);
        update_inputs();
        run(8);
        chk("t4_gain_count", gains.size(), 3);
        chk("t4_gain_old", gains[0], 32'h400);
        chk("t4_gain_new", gains[1], 32'h800);
        chk("t4_gain_left", gains[2], 32'h400);
        chk("t4_rw0", rw[0], 32'h51);

        // Reset with samples in flight
        do_reset();
        lq.push_back(32'h71); lq.push_back(32'h72); lq.push_back(32'h73);
        update_inputs();
        run(3);
        chk("t5_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        clear_log();
        run(10);
        chk("t5_no_l_writes", lw.size(), 0);
        chk("t5_no_r_writes", rw.size(), 0);
        for (int i = 0; i < 9; i++) rq.push_back(32'h80 + i);
        update_inputs();
        run(20);
        chk("t5_credit_8", rg_cyc.size(), 8);

`ifdef GAIN_ARB_MUTE_EN
        // Muted sample is written as zero; the following one is untouched
        do_reset();
        lq.push_back(32'h1234);
        update_inputs();
        mute = 1'b1;
        cycle();
        mute = 1'b0;
        lq.push_back(32'h55);
        update_inputs();
        run(10);
        chk("t6_mute_count", lw.size(), 2);
        chk("t6_muted", lw[0], 32'h0);
        chk("t6_unmuted", lw[1], 32'h55);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
